// File: rtl/boot_pkg.sv
// Shared types and constants for the UART boot loader.
// Optional feature: BOOT_CHECKSUM_EN adds a trailing XOR checksum byte (CSUM state).
package boot_pkg;

  localparam logic [7:0]  BOOT_HEADER = 8'hA5;
  localparam int unsigned ADDR_BYTES  = 4;
  localparam int unsigned LEN_BYTES   = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_LEN,
    ST_DATA,
    ST_WRITE,
`ifdef BOOT_CHECKSUM_EN
    ST_CSUM,
`endif
    ST_DONE
  } boot_state_e;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

endpackage

// File: rtl/uart_boot_loader_if.sv
// System bus write port driven by the boot loader.
//   bus_en_o      one-cycle write request
//   bus_rdwr_o    1 = write (mirrors bus_en_o)
//   bus_mask_o    byte mask, 4'b1111 during writes
//   bus_addr_o    word-aligned address
//   bus_wr_data_o write data
interface uart_boot_loader_if;
  logic        bus_en_o;
  logic        bus_rdwr_o;
  logic [3:0]  bus_mask_o;
  logic [31:0] bus_addr_o;
  logic [31:0] bus_wr_data_o;

  modport master (output bus_en_o, bus_rdwr_o, bus_mask_o, bus_addr_o, bus_wr_data_o);
  modport slave  (input  bus_en_o, bus_rdwr_o, bus_mask_o, bus_addr_o, bus_wr_data_o);
endinterface

// File: rtl/boot_uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, start-bit recheck at half bit,
// center sampling of data and stop bits.
//   clk, rst_n   clock, synchronous active-low reset
//   rxd_i        asynchronous serial input, idle high
//   byte_o       received byte (stable while valid_o is high)
//   valid_o      one-cycle pulse, 1 cycle after a good stop-bit sample
//   frame_err_o  one-cycle pulse, 1 cycle after a stop bit sampled low
module boot_uart_rx
  import boot_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rxd_i,
  output logic [7:0] byte_o,
  output logic       valid_o,
  output logic       frame_err_o
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);

  logic          sync1_q, sync2_q;
  rx_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    sh_q, sh_d;
  logic          valid_d, ferr_d;

  // Synchronizer and state registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      state_q     <= RX_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      sh_q        <= '0;
      valid_o     <= 1'b0;
      frame_err_o <= 1'b0;
    end else begin
      sync1_q     <= rxd_i;
      sync2_q     <= sync1_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      sh_q        <= sh_d;
      valid_o     <= valid_d;
      frame_err_o <= ferr_d;
    end
  end

  // Bit timing and deserializer
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    idx_d   = idx_q;
    sh_d    = sh_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (!sync2_q) state_d = RX_START;
      end
      RX_START: begin
        // Glitch filter: line must still be low at mid start bit
        if (cnt_q == CW'(CLKS_PER_BIT / 2 - 1)) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = sync2_q ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (cnt_q == CW'(CLKS_PER_BIT - 1)) begin
          cnt_d = '0;
          sh_d  = {sync2_q, sh_q[7:1]};
          idx_d = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (cnt_q == CW'(CLKS_PER_BIT - 1)) begin
          cnt_d   = '0;
          valid_d = sync2_q;
          ferr_d  = !sync2_q;
          state_d = RX_IDLE;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  assign byte_o = sh_q;

endmodule

// File: rtl/uart_boot_loader.sv
// UART boot loader: parses A5 | ADDR[4] | LEN[2] | data[LEN*4] (| CSUM) frames
// and writes each word to memory over the system bus.
// Optional feature macro: BOOT_CHECKSUM_EN (trailing XOR checksum byte).
//   clk, rst_n     clock, synchronous active-low reset
//   uart_rxd_i     serial input, 8N1, idle high
//   bus            system bus write port (master modport)
//   boot_active_o  frame in progress
//   done_o         one-cycle pulse on successful frame completion
//   err_o          sticky error, cleared when the next header is accepted
module uart_boot_loader
  import boot_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT   = 868,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 uart_rxd_i,
  uart_boot_loader_if.master   bus,
  output logic                 boot_active_o,
  output logic                 done_o,
  output logic                 err_o
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
`ifdef BOOT_CHECKSUM_EN
  localparam boot_state_e ST_TAIL = ST_CSUM;
`else
  localparam boot_state_e ST_TAIL = ST_DONE;
`endif

  logic [7:0]  rx_byte;
  logic        rx_valid, rx_ferr;

  boot_state_e state_q, state_d;
  logic [1:0]  bcnt_q, bcnt_d;
  logic [31:0] addr_q, addr_d;
  logic [15:0] len_q, len_d;
  logic [31:0] word_q, word_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic        en_q, en_d;
  logic        active_d, done_d, err_d;
`ifdef BOOT_CHECKSUM_EN
  logic [7:0]  csum_q, csum_d;
`endif

  boot_uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk         (clk),
    .rst_n       (rst_n),
    .rxd_i       (uart_rxd_i),
    .byte_o      (rx_byte),
    .valid_o     (rx_valid),
    .frame_err_o (rx_ferr)
  );

  // State, datapath and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      bcnt_q        <= '0;
      addr_q        <= '0;
      len_q         <= '0;
      word_q        <= '0;
      tcnt_q        <= '0;
      en_q          <= 1'b0;
      boot_active_o <= 1'b0;
      done_o        <= 1'b0;
      err_o         <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
      csum_q        <= '0;
`endif
    end else begin
      state_q       <= state_d;
      bcnt_q        <= bcnt_d;
      addr_q        <= addr_d;
      len_q         <= len_d;
      word_q        <= word_d;
      tcnt_q        <= tcnt_d;
      en_q          <= en_d;
      boot_active_o <= active_d;
      done_o        <= done_d;
      err_o         <= err_d;
`ifdef BOOT_CHECKSUM_EN
      csum_q        <= csum_d;
`endif
    end
  end

  // Frame parser; outputs are registered from the next state so they line up with it
  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    addr_d  = addr_q;
    len_d   = len_q;
    word_d  = word_q;
    err_d   = err_q_hold();
    tcnt_d  = (state_q == ST_IDLE || rx_valid) ? '0 : tcnt_q + TW'(1);
`ifdef BOOT_CHECKSUM_EN
    csum_d  = csum_q;
    if (rx_valid && (state_q == ST_ADDR || state_q == ST_LEN || state_q == ST_DATA))
      csum_d = csum_q ^ rx_byte;
`endif
    case (state_q)
      ST_IDLE: begin
        if (rx_valid && rx_byte == BOOT_HEADER) begin
          state_d = ST_ADDR;
          bcnt_d  = '0;
          err_d   = 1'b0;
`ifdef BOOT_CHECKSUM_EN
          csum_d  = '0;
`endif
        end
      end
      ST_ADDR: begin
        if (rx_valid) begin
          bcnt_d = bcnt_q + 2'd1;
          if (bcnt_q == 2'(ADDR_BYTES - 1)) begin
            // Last byte: force word alignment
            addr_d  = {rx_byte, addr_q[31:10], 2'b00};
            bcnt_d  = '0;
            state_d = ST_LEN;
          end else begin
            addr_d = {rx_byte, addr_q[31:8]};
          end
        end
      end
      ST_LEN: begin
        if (rx_valid) begin
          len_d  = {rx_byte, len_q[15:8]};
          bcnt_d = bcnt_q + 2'd1;
          if (bcnt_q == 2'(LEN_BYTES - 1)) begin
            bcnt_d  = '0;
            state_d = ({rx_byte, len_q[15:8]} == 16'd0) ? ST_TAIL : ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (rx_valid) begin
          word_d = {rx_byte, word_q[31:8]};
          bcnt_d = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) begin
            bcnt_d  = '0;
            state_d = ST_WRITE;
          end
        end
      end
      ST_WRITE: begin
        addr_d  = addr_q + 32'd4;
        len_d   = len_q - 16'd1;
        state_d = (len_q == 16'd1) ? ST_TAIL : ST_DATA;
      end
`ifdef BOOT_CHECKSUM_EN
      ST_CSUM: begin
        if (rx_valid) begin
          if (rx_byte == csum_q) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_IDLE;
            err_d   = 1'b1;
          end
        end
      end
`endif
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // Framing error or inter-byte timeout aborts any frame in progress
    if (state_q != ST_IDLE && (rx_ferr || tcnt_d == TW'(TIMEOUT_CYCLES))) begin
      state_d = ST_IDLE;
      err_d   = 1'b1;
    end
    active_d = (state_d != ST_IDLE);
    en_d     = (state_d == ST_WRITE);
    done_d   = (state_d == ST_DONE);
  end

  function automatic logic err_q_hold();
    return err_o;
  endfunction

  assign bus.bus_en_o      = en_q;
  assign bus.bus_rdwr_o    = en_q;
  assign bus.bus_mask_o    = {4{en_q}};
  assign bus.bus_addr_o    = addr_q;
  assign bus.bus_wr_data_o = word_q;

endmodule

// File: tb/tb_uart_boot_loader.sv
// Scoreboard bench for uart_boot_loader (CLKS_PER_BIT=8, TIMEOUT_CYCLES=400).
// Expected bus writes are queued by the stimulus; a monitor pops them on bus_en_o.
module tb_uart_boot_loader;
  localparam int unsigned CPB = 8;
  localparam int unsigned TO  = 400;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rxd = 1'b1;
  logic boot_active_o, done_o, err_o;

  wr_t         exp_q[$];
  logic [31:0] wq[$];
  int vecs = 0;
  int miscompares = 0;
  int done_cnt = 0;

  uart_boot_loader_if bus ();

  uart_boot_loader #(.CLKS_PER_BIT(CPB), .TIMEOUT_CYCLES(TO)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .uart_rxd_i    (rxd),
    .bus           (bus),
    .boot_active_o (boot_active_o),
    .done_o        (done_o),
    .err_o         (err_o)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: pop and compare every write, track done pulses, police idle bus
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.bus_en_o) begin
        if (exp_q.size() == 0) begin
          vecs++;
          miscompares++;
          $display("FAIL unexpected_write: addr 0x%08h data 0x%08h, none expected",
                   bus.bus_addr_o, bus.bus_wr_data_o);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          check("wr_addr", bus.bus_addr_o, e.addr);
          check("wr_data", bus.bus_wr_data_o, e.data);
          check("wr_mask", 32'(bus.bus_mask_o), 32'hF);
          check("wr_rdwr", 32'(bus.bus_rdwr_o), 32'h1);
        end
      end else if (bus.bus_mask_o != 4'h0 || bus.bus_rdwr_o) begin
        miscompares++;
        $display("FAIL idle_bus: mask 0x%0h rdwr %0b while en low", bus.bus_mask_o, bus.bus_rdwr_o);
      end
      if (done_o) done_cnt++;
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit bad_stop);
    rxd = 1'b0;
    repeat (CPB) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (CPB) @(posedge clk);
    end
    rxd = bad_stop ? 1'b0 : 1'b1;
    repeat (CPB) @(posedge clk);
    rxd = 1'b1;
    repeat (2 * CPB) @(posedge clk);
  endtask

  task automatic send_hdr(input logic [31:0] addr, input logic [15:0] len, inout logic [7:0] x);
    send_byte(8'hA5, 1'b0);
    for (int i = 0; i < 4; i++) begin
      x ^= addr[8*i +: 8];
      send_byte(addr[8*i +: 8], 1'b0);
    end
    for (int i = 0; i < 2; i++) begin
      x ^= len[8*i +: 8];
      send_byte(len[8*i +: 8], 1'b0);
    end
  endtask

  // Full frame from wq; expected writes pushed with wrapping word addresses
  task automatic send_frame(input logic [31:0] addr, input logic [7:0] csum_flip);
    logic [7:0] x;
    x = 8'h00;
    send_hdr(addr, 16'(wq.size()), x);
    for (int k = 0; k < wq.size(); k++) begin
      wr_t e;
      e.addr = (addr & 32'hFFFF_FFFC) + 32'(4 * k);
      e.data = wq[k];
      exp_q.push_back(e);
      for (int i = 0; i < 4; i++) begin
        x ^= wq[k][8*i +: 8];
        send_byte(wq[k][8*i +: 8], 1'b0);
      end
    end
`ifdef BOOT_CHECKSUM_EN
    send_byte(x ^ csum_flip, 1'b0);
`else
    if (csum_flip != 8'h00) $display("note: checksum flip ignored without checksum build");
`endif
  endtask

  task automatic finish_frame(input string name, input int done_base, input int exp_done, input logic exp_err);
    int n;
    n = 0;
    while (boot_active_o && n < 600) begin
      @(posedge clk);
      n++;
    end
    @(negedge clk);
    check({name, "_done"}, 32'(done_cnt - done_base), 32'(exp_done));
    check({name, "_err"}, 32'(err_o), 32'(exp_err));
    check({name, "_active"}, 32'(boot_active_o), 32'h0);
    check({name, "_pending"}, 32'(exp_q.size()), 32'h0);
  endtask

  initial begin
    int base;
    logic [7:0] x;

    repeat (4) @(posedge clk);
    @(negedge clk);
    check("rst_active", 32'(boot_active_o), 0);
    check("rst_en", 32'(bus.bus_en_o), 0);
    check("rst_addr", bus.bus_addr_o, 0);
    check("rst_done_err", 32'({done_o, err_o}), 0);
    rst_n = 1'b1;
    repeat (4 * CPB) @(posedge clk);

    // Basic two-word frame
    base = done_cnt;
    wq = {32'h44332211, 32'hDDCCBBAA};
    send_frame(32'h0000_0100, 8'h00);
    finish_frame("basic", base, 1, 1'b0);

    // Noise bytes in IDLE, then a zero-length frame
    base = done_cnt;
    send_byte(8'h00, 1'b0);
    send_byte(8'h5A, 1'b0);
    check("noise_idle_active", 32'(boot_active_o), 0);
    wq.delete();
    send_frame(32'h0000_0200, 8'h00);
    finish_frame("len0", base, 1, 1'b0);

    // Unaligned address near top of memory: alignment plus wraparound
    base = done_cnt;
    wq = {32'h01020304, 32'h05060708};
    send_frame(32'hFFFF_FFFE, 8'h00);
    finish_frame("wrap", base, 1, 1'b0);

    // Inter-byte timeout inside DATA
    base = done_cnt;
    x = 8'h00;
    send_hdr(32'h0000_0300, 16'd2, x);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    repeat (500) @(posedge clk);
    @(negedge clk);
    check("timeout_err", 32'(err_o), 1);
    check("timeout_active", 32'(boot_active_o), 0);
    check("timeout_done", 32'(done_cnt - base), 0);

    // Next valid frame clears the sticky error
    base = done_cnt;
    wq = {32'hCAFEF00D};
    send_frame(32'h0000_0400, 8'h00);
    finish_frame("recover", base, 1, 1'b0);

    // Framing error on the first LEN byte
    base = done_cnt;
    x = 8'h00;
    send_byte(8'hA5, 1'b0);
    for (int i = 0; i < 4; i++) send_byte(8'h10, 1'b0);
    send_byte(8'h01, 1'b1);
    repeat (12 * CPB) @(posedge clk);
    finish_frame("ferr", base, 0, 1'b1);

    // Reset during DATA; header first clears err
    x = 8'h00;
    send_hdr(32'h0000_0500, 16'd1, x);
    @(negedge clk);
    check("hdr_clears_err", 32'(err_o), 0);
    check("rst_mid_active", 32'(boot_active_o), 1);
    send_byte(8'h77, 1'b0);
    send_byte(8'h88, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_active", 32'(boot_active_o), 0);
    check("midrst_addr", bus.bus_addr_o, 0);
    check("midrst_data", bus.bus_wr_data_o, 0);
    check("midrst_ctl", 32'({bus.bus_en_o, bus.bus_rdwr_o, bus.bus_mask_o, done_o, err_o}), 0);
    rst_n = 1'b1;
    repeat (2 * CPB) @(posedge clk);
    base = done_cnt;
    wq = {32'h12345678};
    send_frame(32'h0000_0600, 8'h00);
    finish_frame("post_rst", base, 1, 1'b0);

`ifdef BOOT_CHECKSUM_EN
    // Correct checksum
    base = done_cnt;
    wq = {32'h0BADBEEF, 32'h87654321};
    send_frame(32'h0000_0700, 8'h00);
    finish_frame("csum_ok", base, 1, 1'b0);

    // Corrupted checksum: writes still happen, no done, error set
    base = done_cnt;
    wq = {32'hA0A1A2A3};
    send_frame(32'h0000_0800, 8'h01);
    finish_frame("csum_bad", base, 0, 1'b1);
`endif

    repeat (4) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end

endmodule
